// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the parametrised add-and-shift multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bits needed to hold the values 0..width (clog2(width+1)).
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned w;
      w = 1;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < (64'(width) + 64'd1)) w = i + 1;
      end
      return w;
   endfunction

   function automatic int unsigned res_width(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/add_shift_dp.sv
// Datapath: operand magnitude capture, conditional add, right shift and
// sign correction of the final product.
module add_shift_dp
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned SIGNED_EN = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_load,
   input  logic                          i_step,
   input  logic                          i_fix,
   input  logic                          i_is_signed,
   input  logic [WIDTH-1:0]              i_a,
   input  logic [WIDTH-1:0]              i_b,
   output logic [res_width(WIDTH)-1:0]   o_result
);

   localparam int unsigned RES_W  = res_width(WIDTH);
   localparam bit          SGN_OK = (SIGNED_EN != 0);

   logic [WIDTH-1:0] r_areg;
   logic [WIDTH-1:0] r_breg;
   logic [WIDTH-1:0] r_preg;
   logic             r_neg;
   logic [RES_W-1:0] r_result;

   logic             w_sgn;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_sum;
   logic [RES_W-1:0] w_prod;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
   // exactly right when the register is read as unsigned.
   assign w_sgn   = SGN_OK & i_is_signed;
   assign w_a_mag = (w_sgn && i_a[WIDTH-1]) ? WIDTH'(-i_a) : i_a;
   assign w_b_mag = (w_sgn && i_b[WIDTH-1]) ? WIDTH'(-i_b) : i_b;

   // Carry lives in w_sum[WIDTH] and is shifted straight into the product.
   assign w_sum  = {1'b0, r_preg} + {1'b0, (r_areg[0] ? r_breg : WIDTH'(0))};
   assign w_prod = {r_preg, r_areg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_areg   <= '0;
         r_breg   <= '0;
         r_preg   <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else if (i_load) begin
         r_areg <= w_a_mag;
         r_breg <= w_b_mag;
         r_preg <= '0;
         r_neg  <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      end else if (i_step) begin
         r_preg <= w_sum[WIDTH:1];
         r_areg <= {w_sum[0], r_areg[WIDTH-1:1]};
      end else if (i_fix) begin
         r_result <= r_neg ? RES_W'(-w_prod) : w_prod;
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/add_shift_mult_param.sv
// Sequential add-and-shift multiplier: controller FSM and iteration counter
// around the add_shift_dp datapath, behind a start/ready handshake.
module add_shift_mult_param
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned SIGNED_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     is_signed,
   input  logic [WIDTH-1:0]         ABus,
   input  logic [WIDTH-1:0]         BBus,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [2*WIDTH-1:0]       resultBus
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam int unsigned RES_W = res_width(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             w_load;
   logic             w_step;
   logic             w_fix;
   logic [RES_W-1:0] w_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (start) w_next = CALC;
         CALC: if (r_cnt == CNT_W'(1)) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_load = 1'b0;
      w_step = 1'b0;
      w_fix  = 1'b0;
      case (r_state)
         IDLE: w_load = start;
         CALC: w_step = 1'b1;
         FIX:  w_fix  = 1'b1;
         default: ;
      endcase
   end

   // Counter and handshake outputs, registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_load)      r_cnt <= CNT_W'(WIDTH);
         else if (w_step) r_cnt <= r_cnt - CNT_W'(1);
         r_ready <= (w_next == IDLE);
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
      end
   end

   add_shift_dp #(
      .WIDTH     (WIDTH),
      .SIGNED_EN (SIGNED_EN)
   ) u_dp (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_fix       (w_fix),
      .i_is_signed (is_signed),
      .i_a         (ABus),
      .i_b         (BBus),
      .o_result    (w_result)
   );

   assign ready     = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign resultBus = w_result;

endmodule

// File: tb/tb_add_shift_mult_param.sv
// Directed bench: three multiplier instances (4-bit signed-capable, 8-bit
// signed-capable, 8-bit unsigned-only) with hand-computed products.
module tb_add_shift_mult_param;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       st0 = 0, sg0 = 0;
   logic [3:0] a0 = 0, b0 = 0;
   logic       rdy0, bsy0, dn0;
   logic [7:0] res0;

   logic       st1 = 0, sg1 = 0;
   logic [7:0] a1 = 0, b1 = 0;
   logic       rdy1, bsy1, dn1;
   logic [15:0] res1;

   logic       st2 = 0, sg2 = 0;
   logic [7:0] a2 = 0, b2 = 0;
   logic       rdy2, bsy2, dn2;
   logic [15:0] res2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   add_shift_mult_param #(.WIDTH(4), .SIGNED_EN(1)) u_m4 (
      .clk(clk), .rst(rst), .start(st0), .is_signed(sg0), .ABus(a0), .BBus(b0),
      .ready(rdy0), .busy(bsy0), .done(dn0), .resultBus(res0));

   add_shift_mult_param #(.WIDTH(8), .SIGNED_EN(1)) u_m8s (
      .clk(clk), .rst(rst), .start(st1), .is_signed(sg1), .ABus(a1), .BBus(b1),
      .ready(rdy1), .busy(bsy1), .done(dn1), .resultBus(res1));

   add_shift_mult_param #(.WIDTH(8), .SIGNED_EN(0)) u_m8u (
      .clk(clk), .rst(rst), .start(st2), .is_signed(sg2), .ABus(a2), .BBus(b2),
      .ready(rdy2), .busy(bsy2), .done(dn2), .resultBus(res2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int u, input bit st, input bit s,
                         input logic [7:0] a, input logic [7:0] b);
      case (u)
         0: begin st0 = st; sg0 = s; a0 = a[3:0]; b0 = b[3:0]; end
         1: begin st1 = st; sg1 = s; a1 = a; b1 = b; end
         default: begin st2 = st; sg2 = s; a2 = a; b2 = b; end
      endcase
   endtask

   function automatic logic get_done(input int u);
      return (u == 0) ? dn0 : (u == 1) ? dn1 : dn2;
   endfunction

   function automatic logic get_ready(input int u);
      return (u == 0) ? rdy0 : (u == 1) ? rdy1 : rdy2;
   endfunction

   function automatic logic [15:0] get_res(input int u);
      return (u == 0) ? {8'h00, res0} : (u == 1) ? res1 : res2;
   endfunction

   // One full transaction: latency to done, product, and return to ready.
   task automatic do_op(input int u, input bit s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input string tag);
      int n;
      bit got;
      int w;
      w = (u == 0) ? 4 : 8;
      @(negedge clk);
      check({tag, "_ready_in"}, 32'(get_ready(u)), 32'd1);
      set_in(u, 1'b1, s, a, b);
      @(posedge clk);
      #1 set_in(u, 1'b0, s, a, b);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (get_done(u)) got = 1'b1;
      end
      check({tag, "_latency"}, 32'(n), 32'(w + 1));
      check({tag, "_result"}, 32'(get_res(u)), 32'(exp));
      @(posedge clk);
      #1;
      check({tag, "_ready_out"}, 32'(get_ready(u)), 32'd1);
      check({tag, "_done_pulse"}, 32'(get_done(u)), 32'd0);
   endtask

   initial begin
      int ndone;
      logic [15:0] seen;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(rdy0), 32'd1);
      check("rst_busy",  32'(bsy0), 32'd0);
      check("rst_done",  32'(dn0),  32'd0);
      check("rst_result", 32'(res0), 32'd0);
      @(negedge clk) rst = 1'b0;

      do_op(0, 1'b0, 8'd15, 8'd15, 16'h00E1, "u4_15x15");
      do_op(0, 1'b1, 8'h08, 8'h07, 16'h00C8, "s4_m8x7");
      do_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, "s4_m8xm8");
      do_op(0, 1'b1, 8'h03, 8'h0B, 16'h00F1, "s4_3xm5");
      do_op(0, 1'b1, 8'h00, 8'h0B, 16'h0000, "s4_0xm5");
      do_op(0, 1'b0, 8'h01, 8'h0F, 16'h000F, "u4_1xF");

      // Start pulsed and buses changed mid-CALC: ignored, one done only.
      @(negedge clk);
      set_in(0, 1'b1, 1'b0, 8'd7, 8'd9);
      @(posedge clk);
      #1 set_in(0, 1'b0, 1'b0, 8'd7, 8'd9);
      @(posedge clk);
      #1;
      check("hold_old_result", 32'(res0), 32'h0F);
      check("busy_in_calc", 32'(bsy0), 32'd1);
      set_in(0, 1'b1, 1'b1, 8'hF, 8'hF);
      @(posedge clk);
      #1 set_in(0, 1'b0, 1'b0, 8'h3, 8'h3);
      ndone = 0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (dn0) begin
            ndone++;
            seen = {8'h00, res0};
         end
      end
      check("ignore_start_dones", 32'(ndone), 32'd1);
      check("ignore_start_result", 32'(seen), 32'h3F);
      check("ignore_start_ready", 32'(rdy0), 32'd1);

      do_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u8_255x255");
      do_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, "s8_m128xm128");
      do_op(1, 1'b1, 8'hFD, 8'h05, 16'hFFF1, "s8_m3x5");
      do_op(2, 1'b1, 8'hFF, 8'h02, 16'h01FE, "nosgn_FFx02");

      // Reset during the third CALC cycle aborts the operation.
      @(negedge clk);
      set_in(0, 1'b1, 1'b0, 8'd13, 8'd11);
      @(posedge clk);
      #1 set_in(0, 1'b0, 1'b0, 8'd13, 8'd11);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_ready", 32'(rdy0), 32'd1);
      check("abort_busy", 32'(bsy0), 32'd0);
      check("abort_result", 32'(res0), 32'd0);
      check("abort_done", 32'(dn0), 32'd0);
      @(negedge clk) rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (dn0) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      do_op(0, 1'b0, 8'd3, 8'd5, 16'h000F, "post_abort_3x5");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
